mem_stage: RTL and testbench

Memory-access stage directly downstream of the execute stage. It consumes the ALU result, store data and control from execute, and drives the data-memory bus with a req/gnt/rvalid handshake for loads and stores. It formats store bytes and sign- or zero-extends load data. It registers the result for write-back and back-pressures execute while a bus transaction is outstanding.

---
 rtl/mem_stage.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// =============================================================================
// mem_stage -- memory-access pipeline stage (downstream of execute)
//
// Purpose:
//   Takes the ALU result, store data and control from execute. Non-memory
//   instructions pass straight through with one cycle of latency. Loads and
//   stores drive the data bus with a req/gnt/rvalid handshake. Store data is
//   replicated across byte lanes and load data is sign- or zero-extended.
//   The result is registered for write-back as a single-cycle out_valid pulse.
//   Execute is held off (in_ready=0) while a bus transaction is outstanding.
//
// Optional feature (compile-time macro):
//   MEM_STAGE_MISALIGN_TRAP_EN
//     Defined   : a misaligned half or word access never reaches the bus. It
//                 completes in one cycle as a pass-through with
//                 out_misalign=1, out_rf_en=0 and out_ld_data=0.
//     Undefined : out_misalign is always 0. The low address bits are dropped
//                 and the access is issued word-aligned.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   handshake with execute
//   opr_res, opr_b      ALU result (effective address) and store data
//   rd, rf_en, wb_sel   write-back control, propagated to the outputs
//   dm_en, dm_we        memory access enable / store select
//   dm_size             funct3 access size (stores use bits [1:0])
//   dbus_*              data-memory bus (req/gnt/rvalid handshake)
//   out_*               registered results for write-back
// =============================================================================
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] opr_res,
    input  logic [DATA_WIDTH-1:0] opr_b,
    input  logic [4:0]            rd,
    input  logic                  rf_en,
    input  logic                  dm_en,
    input  logic                  dm_we,
    input  logic [2:0]            dm_size,
    input  logic [1:0]            wb_sel,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [DATA_WIDTH-1:0] dbus_addr,
    output logic [BE_WIDTH-1:0]   dbus_be,
    output logic [DATA_WIDTH-1:0] dbus_wdata,
    input  logic                  dbus_gnt,
    input  logic                  dbus_rvalid,
    input  logic [DATA_WIDTH-1:0] dbus_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_opr_res,
    output logic [DATA_WIDTH-1:0] out_ld_data,
    output logic [4:0]            out_rd,
    output logic                  out_rf_en,
    output logic [1:0]            out_wb_sel,
    output logic                  out_misalign
);

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Helper functions. Only size[1:0] matters for lane selection, so
    // reserved load sizes (011, 110, 111) fall into the word case.
    // ---------------------------------------------------------------------
    function automatic logic [BE_WIDTH-1:0] store_be(input logic [2:0] size,
                                                     input logic [1:0] off);
        case (size[1:0])
            2'b00:   return 4'b0001 << off;
            // off[0] is dropped so that a half access never straddles lanes
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] size,
                                                         input logic [DATA_WIDTH-1:0] data);
        case (size[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] size,
                                                          input logic [1:0] off,
                                                          input logic [DATA_WIDTH-1:0] rdata);
        logic [DATA_WIDTH-1:0] byte_sh;
        logic [DATA_WIDTH-1:0] half_sh;
        logic [7:0]            b;
        logic [15:0]           h;
        byte_sh = rdata >> {off, 3'b000};
        half_sh = rdata >> {off[1], 4'b0000};
        b       = byte_sh[7:0];
        h       = half_sh[15:0];
        // size[2] set means the unsigned variants LBU/LHU
        case (size[1:0])
            2'b00:   return size[2] ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   return size[2] ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [1:0] off);
        case (size[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Signals
    // ---------------------------------------------------------------------
    state_t                  state_r;
    state_t                  state_next_s;
    logic                    in_ready_s;
    logic                    req_s;
    logic                    misalign_s;
    logic                    done_s;

    logic                    dbus_we_r;
    logic [DATA_WIDTH-1:0]   dbus_addr_r;
    logic [BE_WIDTH-1:0]     dbus_be_r;
    logic [DATA_WIDTH-1:0]   dbus_wdata_r;
    logic [2:0]              size_r;
    logic [1:0]              off_r;
    logic [DATA_WIDTH-1:0]   opr_res_r;
    logic [4:0]              rd_r;
    logic                    rf_en_r;
    logic [1:0]              wb_sel_r;

    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   out_opr_res_r;
    logic [DATA_WIDTH-1:0]   out_ld_data_r;
    logic [4:0]              out_rd_r;
    logic                    out_rf_en_r;
    logic [1:0]              out_wb_sel_r;
    logic                    out_misalign_r;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign_s = dm_en && is_misaligned(dm_size, opr_res[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // A transaction finishes on rvalid in RSP, or on gnt+rvalid together in REQ
    assign done_s = ((state_r == ST_REQ) && dbus_gnt && dbus_rvalid) ||
                    ((state_r == ST_RSP) && dbus_rvalid);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && dm_en && !misalign_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dbus_gnt && dbus_rvalid) begin
                    state_next_s = ST_IDLE;
                end else if (dbus_gnt) begin
                    state_next_s = ST_RSP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RSP: begin
                if (dbus_rvalid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RSP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        in_ready_s = 1'b0;
        req_s      = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_REQ:  req_s      = 1'b1;
            ST_RSP:  req_s      = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Request capture and write-back result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_we_r      <= 1'b0;
            dbus_addr_r    <= ZERO_W;
            dbus_be_r      <= 4'b0000;
            dbus_wdata_r   <= ZERO_W;
            size_r         <= 3'b000;
            off_r          <= 2'b00;
            opr_res_r      <= ZERO_W;
            rd_r           <= 5'd0;
            rf_en_r        <= 1'b0;
            wb_sel_r       <= 2'b00;
            out_valid_r    <= 1'b0;
            out_opr_res_r  <= ZERO_W;
            out_ld_data_r  <= ZERO_W;
            out_rd_r       <= 5'd0;
            out_rf_en_r    <= 1'b0;
            out_wb_sel_r   <= 2'b00;
            out_misalign_r <= 1'b0;
        end else begin
            // out_valid, out_rf_en and out_misalign are one-cycle pulses
            out_valid_r    <= 1'b0;
            out_rf_en_r    <= 1'b0;
            out_misalign_r <= 1'b0;
            if ((state_r == ST_IDLE) && in_valid) begin
                if (!dm_en || misalign_s) begin
                    // Pass-through, including trapped misaligned accesses
                    out_valid_r    <= 1'b1;
                    out_opr_res_r  <= opr_res;
                    out_ld_data_r  <= ZERO_W;
                    out_rd_r       <= rd;
                    out_rf_en_r    <= rf_en && !misalign_s;
                    out_wb_sel_r   <= wb_sel;
                    out_misalign_r <= misalign_s;
                end else begin
                    // Bus fields are held from here until the next accept
                    dbus_we_r    <= dm_we;
                    dbus_addr_r  <= {opr_res[DATA_WIDTH-1:2], 2'b00};
                    dbus_be_r    <= dm_we ? store_be(dm_size, opr_res[1:0]) : 4'b1111;
                    dbus_wdata_r <= dm_we ? store_data(dm_size, opr_b) : ZERO_W;
                    size_r       <= dm_size;
                    off_r        <= opr_res[1:0];
                    opr_res_r    <= opr_res;
                    rd_r         <= rd;
                    rf_en_r      <= rf_en;
                    wb_sel_r     <= wb_sel;
                end
            end else if (done_s) begin
                out_valid_r   <= 1'b1;
                out_opr_res_r <= opr_res_r;
                out_ld_data_r <= dbus_we_r ? ZERO_W : load_extend(size_r, off_r, dbus_rdata);
                out_rd_r      <= rd_r;
                out_rf_en_r   <= rf_en_r;
                out_wb_sel_r  <= wb_sel_r;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign dbus_req     = req_s;
    assign dbus_we      = dbus_we_r;
    assign dbus_addr    = dbus_addr_r;
    assign dbus_be      = dbus_be_r;
    assign dbus_wdata   = dbus_wdata_r;
    assign out_valid    = out_valid_r;
    assign out_opr_res  = out_opr_res_r;
    assign out_ld_data  = out_ld_data_r;
    assign out_rd       = out_rd_r;
    assign out_rf_en    = out_rf_en_r;
    assign out_wb_sel   = out_wb_sel_r;
    assign out_misalign = out_misalign_r;

endmodule

// File: tb/tb_mem_stage.sv
// =============================================================================
// tb_mem_stage -- directed self-checking bench for mem_stage
// =============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opr_res;
    logic [31:0] opr_b;
    logic [4:0]  rd;
    logic        rf_en;
    logic        dm_en;
    logic        dm_we;
    logic [2:0]  dm_size;
    logic [1:0]  wb_sel;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        out_valid;
    logic [31:0] out_opr_res;
    logic [31:0] out_ld_data;
    logic [4:0]  out_rd;
    logic        out_rf_en;
    logic [1:0]  out_wb_sel;
    logic        out_misalign;

    int checks_r;
    int errors_r;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opr_res      (opr_res),
        .opr_b        (opr_b),
        .rd           (rd),
        .rf_en        (rf_en),
        .dm_en        (dm_en),
        .dm_we        (dm_we),
        .dm_size      (dm_size),
        .wb_sel       (wb_sel),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_be      (dbus_be),
        .dbus_wdata   (dbus_wdata),
        .dbus_gnt     (dbus_gnt),
        .dbus_rvalid  (dbus_rvalid),
        .dbus_rdata   (dbus_rdata),
        .out_valid    (out_valid),
        .out_opr_res  (out_opr_res),
        .out_ld_data  (out_ld_data),
        .out_rd       (out_rd),
        .out_rf_en    (out_rf_en),
        .out_wb_sel   (out_wb_sel),
        .out_misalign (out_misalign)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] data);
        in_valid = 1'b1;
        dm_en    = 1'b1;
        dm_we    = we;
        dm_size  = size;
        opr_res  = addr;
        opr_b    = data;
        rd       = 5'd7;
        rf_en    = !we;
        wb_sel   = 2'b01;
    endtask

    // Load with gnt and rvalid in the same cycle; checks the issued address
    task automatic fast_load(input string tag, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
        drive_mem(1'b0, size, addr, 32'h0);
        step();
        in_valid = 1'b0;
        check({tag, "_req"}, {31'd0, dbus_req}, 32'd1);
        check({tag, "_addr"}, dbus_addr, exp_addr);
        check({tag, "_be"}, {28'd0, dbus_be}, 32'hF);
        dbus_gnt    = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = rdata;
        step();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, out_ld_data, exp_data);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks_r    = 0;
        errors_r    = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        opr_res     = 32'h0;
        opr_b       = 32'h0;
        rd          = 5'd0;
        rf_en       = 1'b0;
        dm_en       = 1'b0;
        dm_we       = 1'b0;
        dm_size     = 3'b000;
        wb_sel      = 2'b00;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;

        // Reset state
        step();
        step();
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_req", {31'd0, dbus_req}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_addr", dbus_addr, 32'h0);
        check("rst_res", out_opr_res, 32'h0);
        rst = 1'b0;
        step();

        // ALU pass-through
        in_valid = 1'b1;
        dm_en    = 1'b0;
        opr_res  = 32'h1234_5678;
        rd       = 5'd5;
        rf_en    = 1'b1;
        wb_sel   = 2'b10;
        step();
        in_valid = 1'b0;
        check("pt_valid", {31'd0, out_valid}, 32'd1);
        check("pt_res", out_opr_res, 32'h1234_5678);
        check("pt_rd", {27'd0, out_rd}, 32'd5);
        check("pt_rfen", {31'd0, out_rf_en}, 32'd1);
        check("pt_wbsel", {30'd0, out_wb_sel}, 32'd2);
        check("pt_ld", out_ld_data, 32'h0);
        check("pt_noreq", {31'd0, dbus_req}, 32'd0);
        step();
        check("pt_pulse", {31'd0, out_valid}, 32'd0);
        check("pt_rfen_q", {31'd0, out_rf_en}, 32'd0);

        // Load extension at various offsets
        fast_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'hFFFF_FF80);
        fast_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 32'h0000_0080);
        fast_load("lh", 3'b001, 32'h0000_0102, 32'h80FF_0000, 32'h0000_0100, 32'hFFFF_80FF);
        fast_load("lhu", 3'b101, 32'h0000_0102, 32'h80FF_0000, 32'h0000_0100, 32'h0000_80FF);
        fast_load("lb0", 3'b000, 32'h0000_0100, 32'h0000_007F, 32'h0000_0100, 32'h0000_007F);
        fast_load("lw", 3'b010, 32'h0000_0104, 32'h80FF_0001, 32'h0000_0104, 32'h80FF_0001);
        fast_load("lrsv", 3'b111, 32'h0000_0108, 32'h8765_4321, 32'h0000_0108, 32'h8765_4321);

        // SH at 0x202, gnt delayed 3 cycles, fields held stable
        drive_mem(1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("sh_req", {31'd0, dbus_req}, 32'd1);
            check("sh_we", {31'd0, dbus_we}, 32'd1);
            check("sh_addr", dbus_addr, 32'h0000_0200);
            check("sh_be", {28'd0, dbus_be}, 32'hC);
            check("sh_wdata", dbus_wdata, 32'hBEEF_BEEF);
            check("sh_rdy", {31'd0, in_ready}, 32'd0);
            if (i == 3) begin
                dbus_gnt = 1'b1;
            end
            step();
        end
        dbus_gnt = 1'b0;
        check("sh_rsp_req", {31'd0, dbus_req}, 32'd0);
        check("sh_rsp_rdy", {31'd0, in_ready}, 32'd0);
        check("sh_rsp_vld", {31'd0, out_valid}, 32'd0);
        dbus_rvalid = 1'b1;
        step();
        dbus_rvalid = 1'b0;
        check("sh_vld", {31'd0, out_valid}, 32'd1);
        check("sh_ld", out_ld_data, 32'h0);
        check("sh_rfen", {31'd0, out_rf_en}, 32'd0);
        check("sh_res", out_opr_res, 32'h0000_0202);

        // SB at 0x201
        drive_mem(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5);
        step();
        in_valid = 1'b0;
        check("sb_be", {28'd0, dbus_be}, 32'h2);
        check("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
        dbus_gnt    = 1'b1;
        dbus_rvalid = 1'b1;
        step();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        check("sb_vld", {31'd0, out_valid}, 32'd1);

        // LW at 0x40: gnt in cycle 1, rvalid in cycle 4, then back-to-back LW
        drive_mem(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        step();
        in_valid = 1'b0;
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        check("dl_rsp_req", {31'd0, dbus_req}, 32'd0);
        step();
        check("dl_wait1", {31'd0, out_valid}, 32'd0);
        step();
        check("dl_wait2", {31'd0, out_valid}, 32'd0);
        drive_mem(1'b0, 3'b010, 32'h0000_0044, 32'h0);
        check("dl_rdy_busy", {31'd0, in_ready}, 32'd0);
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hDEAD_BEEF;
        step();
        dbus_rvalid = 1'b0;
        check("dl_vld", {31'd0, out_valid}, 32'd1);
        check("dl_data", out_ld_data, 32'hDEAD_BEEF);
        check("dl_rdy", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("b2b_pulse", {31'd0, out_valid}, 32'd0);
        check("b2b_req", {31'd0, dbus_req}, 32'd1);
        check("b2b_addr", dbus_addr, 32'h0000_0044);
        dbus_gnt    = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h1122_3344;
        step();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        check("b2b_data", out_ld_data, 32'h1122_3344);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        // Misaligned LW trapped without a bus request
        drive_mem(1'b0, 3'b010, 32'h0000_0041, 32'h0);
        step();
        in_valid = 1'b0;
        check("mis_req", {31'd0, dbus_req}, 32'd0);
        check("mis_vld", {31'd0, out_valid}, 32'd1);
        check("mis_flag", {31'd0, out_misalign}, 32'd1);
        check("mis_rfen", {31'd0, out_rf_en}, 32'd0);
        check("mis_ld", out_ld_data, 32'h0);
`else
        // Misaligned LW issued word-aligned, flag stays low
        fast_load("mis", 3'b010, 32'h0000_0041, 32'hCAFE_F00D, 32'h0000_0040, 32'hCAFE_F00D);
        check("mis_flag", {31'd0, out_misalign}, 32'd0);
`endif
        step();

        // Reset in the middle of REQ, then stray gnt/rvalid
        drive_mem(1'b0, 3'b010, 32'h0000_0080, 32'h0);
        step();
        in_valid = 1'b0;
        check("mr_req", {31'd0, dbus_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_req0", {31'd0, dbus_req}, 32'd0);
        check("mr_vld0", {31'd0, out_valid}, 32'd0);
        check("mr_rdy", {31'd0, in_ready}, 32'd1);
        check("mr_addr", dbus_addr, 32'h0);
        dbus_gnt    = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h5555_AAAA;
        step();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        check("mr_stray_vld", {31'd0, out_valid}, 32'd0);
        check("mr_stray_req", {31'd0, dbus_req}, 32'd0);
        step();
        check("mr_stray_vld2", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
